// File: rtl/ibex_rf_write_arbiter.sv
// ibex_rf_write_arbiter
//   Shares the single write port of the Ibex flip-flop register file between
//   NumReq writeback requesters. One request is granted per cycle in
//   round-robin order and the granted write is presented on a registered
//   write port one cycle later.
//
//   Optional feature macro: IBEX_RF_ARB_SCOREBOARD_EN
//     defined     : per-register busy scoreboard (set by reservations from the
//                   issue stage, cleared by accepted writes) feeding the
//                   read-after-write hazard outputs.
//     not defined : no scoreboard state, busy_o tied to zero, hazards only
//                   report the write currently in flight on the write port.
//
// Ports
//   clk_i, rst_i         clock, asynchronous active-high reset
//   req_valid_i          per-requester write request
//   req_addr_i           per-requester destination address (5 bits each)
//   req_data_i           per-requester write data (DataWidth bits each)
//   req_ready_o          one-hot grant, request consumed this cycle
//   rf_we_o/waddr/wdata  registered register-file write port
//   illegal_addr_o       pulse: RV32E request to x16..x31 was dropped
//   resv_valid_i/addr_i  destination-register reservation
//   raddr_a_i/raddr_b_i  read addresses presented to the register file
//   hazard_a_o/hazard_b_o read port would return stale data
//   busy_o               scoreboard bit per register
module ibex_rf_write_arbiter #(
  parameter int NumReq    = 3,
  parameter int DataWidth = 32,
  parameter int RV32E     = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NumReq-1:0]           req_valid_i,
  input  logic [NumReq*5-1:0]         req_addr_i,
  input  logic [NumReq*DataWidth-1:0] req_data_i,
  output logic [NumReq-1:0]           req_ready_o,
  output logic                        rf_we_o,
  output logic [4:0]                  rf_waddr_o,
  output logic [DataWidth-1:0]        rf_wdata_o,
  output logic                        illegal_addr_o,
  input  logic                        resv_valid_i,
  input  logic [4:0]                  resv_addr_i,
  input  logic [4:0]                  raddr_a_i,
  input  logic [4:0]                  raddr_b_i,
  output logic                        hazard_a_o,
  output logic                        hazard_b_o,
  output logic [31:0]                 busy_o
);

  localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [PtrW-1:0]      r_ptr;
  logic                 r_we;
  logic [4:0]           r_waddr;
  logic [DataWidth-1:0] r_wdata;
  logic                 r_illegal;

  logic [NumReq-1:0]    w_mask;
  logic [NumReq-1:0]    w_hi;
  logic [NumReq-1:0]    w_sel;
  logic                 w_gnt_any;
  logic [PtrW-1:0]      w_gnt_idx;
  logic [NumReq-1:0]    w_gnt_onehot;
  logic [4:0]           w_gnt_addr;
  logic [DataWidth-1:0] w_gnt_data;
  logic                 w_illegal;
  logic                 w_write;
  logic [PtrW-1:0]      w_ptr_next;

  // Requesters at or after the pointer take priority; if none of them is
  // valid the search wraps to the lowest valid index overall.
  for (genvar gi = 0; gi < NumReq; gi++) begin : g_mask
    assign w_mask[gi] = (r_ptr <= PtrW'(gi));
  end

  assign w_hi  = req_valid_i & w_mask;
  assign w_sel = (|w_hi) ? w_hi : req_valid_i;

  // Lowest set bit of w_sel; descending loop so the lowest index wins.
  always_comb begin
    w_gnt_any    = 1'b0;
    w_gnt_idx    = '0;
    w_gnt_onehot = '0;
    w_gnt_addr   = '0;
    w_gnt_data   = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (w_sel[i]) begin
        w_gnt_any    = 1'b1;
        w_gnt_idx    = PtrW'(i);
        w_gnt_onehot = '0;
        w_gnt_onehot[i] = 1'b1;
        w_gnt_addr   = req_addr_i[i*5 +: 5];
        w_gnt_data   = req_data_i[i*DataWidth +: DataWidth];
      end
    end
    // No request is consumed while reset is held.
    if (rst_i) begin
      w_gnt_any    = 1'b0;
      w_gnt_onehot = '0;
    end
  end

  assign req_ready_o = w_gnt_onehot;
  assign w_illegal   = (RV32E != 0) && w_gnt_addr[4];
  // x0 and dropped RV32E writes are consumed but never reach the file.
  assign w_write     = w_gnt_any && !w_illegal && (w_gnt_addr != 5'd0);
  assign w_ptr_next  = (w_gnt_idx == PtrW'(NumReq - 1)) ? '0 : w_gnt_idx + PtrW'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr     <= '0;
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_illegal <= 1'b0;
    end else begin
      if (w_gnt_any) begin
        r_ptr <= w_ptr_next;
      end
      r_we      <= w_write;
      r_illegal <= w_gnt_any && w_illegal;
      if (w_write) begin
        r_waddr <= w_gnt_addr;
        r_wdata <= w_gnt_data;
      end
    end
  end

  assign rf_we_o        = r_we;
  assign rf_waddr_o     = r_waddr;
  assign rf_wdata_o     = r_wdata;
  assign illegal_addr_o = r_illegal;

  // A write on the port this cycle lands at the end of the cycle, so a read
  // of the same register still sees the old value.
  logic w_inflight_a;
  logic w_inflight_b;
  assign w_inflight_a = r_we && (r_waddr == raddr_a_i) && (raddr_a_i != 5'd0);
  assign w_inflight_b = r_we && (r_waddr == raddr_b_i) && (raddr_b_i != 5'd0);

`ifdef IBEX_RF_ARB_SCOREBOARD_EN
  logic [31:0] r_busy;
  logic [31:0] w_set;
  logic [31:0] w_clr;

  assign w_set = resv_valid_i ? (32'd1 << resv_addr_i) : 32'd0;
  assign w_clr = w_write ? (32'd1 << w_gnt_addr) : 32'd0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_busy <= '0;
    end else begin
      // Set after clear: a reservation in the same cycle as the retiring
      // write belongs to a younger instruction and must survive.
      r_busy <= ((r_busy & ~w_clr) | w_set) & 32'hFFFF_FFFE;
    end
  end

  assign busy_o     = r_busy;
  assign hazard_a_o = r_busy[raddr_a_i] | w_inflight_a;
  assign hazard_b_o = r_busy[raddr_b_i] | w_inflight_b;
`else
  logic w_unused_resv;
  assign w_unused_resv = ^{resv_valid_i, resv_addr_i};

  assign busy_o     = 32'd0;
  assign hazard_a_o = w_inflight_a;
  assign hazard_b_o = w_inflight_b;
`endif

endmodule
